// File: rtl/ysyx_22050133_lsu_pkg.sv
// Shared constants for the load/store unit: ctrl_mem bit layout, access sizes,
// FSM state encodings, and the captured-request payload.
package ysyx_22050133_lsu_pkg;

   localparam int unsigned XLEN                      = 64;
   localparam int unsigned REG_W                     = 5;
   localparam int unsigned WMASK_W                   = 8;
   localparam int unsigned ysyx_22050133_ctrl_mem_len = 5;

   localparam int unsigned CTRL_MEM_BIT   = 4;
   localparam int unsigned CTRL_STORE_BIT = 3;
   localparam int unsigned CTRL_UNS_BIT   = 2;

   localparam logic [1:0] MEM_B = 2'd0;
   localparam logic [1:0] MEM_H = 2'd1;
   localparam logic [1:0] MEM_W = 2'd2;
   localparam logic [1:0] MEM_D = 2'd3;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   // Only what the response path needs is kept after acceptance
   typedef struct packed {
      logic       store;
      logic       uns;
      logic [1:0] size;
      logic [2:0] off;
   } lsu_req_t;

endpackage

// File: rtl/ysyx_22050133_lsu_align.sv
// Byte-lane helper: store lane shift and mask, load extraction/extension,
// and the natural-alignment check.
module ysyx_22050133_lsu_align
   import ysyx_22050133_lsu_pkg::*;
(
   input  logic               store,
   input  logic               uns,
   input  logic [1:0]         size,
   input  logic [2:0]         off,
   input  logic [XLEN-1:0]    wdata,
   input  logic [XLEN-1:0]    rdata,
   output logic [XLEN-1:0]    lane_wdata_c,
   output logic [WMASK_W-1:0] wmask_c,
   output logic [XLEN-1:0]    load_data_c,
   output logic               misaligned_c
);

   logic [XLEN-1:0]    shifted;
   logic [WMASK_W-1:0] base_mask;

   always_comb begin
      lane_wdata_c = wdata << {off, 3'b000};
      shifted      = rdata >> {off, 3'b000};
      base_mask    = '0;
      load_data_c  = '0;
      misaligned_c = 1'b0;
      case (size)
         MEM_B: begin
            base_mask   = 8'h01;
            load_data_c = uns ? XLEN'(shifted[7:0]) : {{56{shifted[7]}}, shifted[7:0]};
         end
         MEM_H: begin
            base_mask    = 8'h03;
            misaligned_c = off[0];
            load_data_c  = uns ? XLEN'(shifted[15:0]) : {{48{shifted[15]}}, shifted[15:0]};
         end
         MEM_W: begin
            base_mask    = 8'h0f;
            misaligned_c = |off[1:0];
            load_data_c  = uns ? XLEN'(shifted[31:0]) : {{32{shifted[31]}}, shifted[31:0]};
         end
         default: begin
            base_mask    = 8'hff;
            misaligned_c = |off;
            load_data_c  = shifted;
         end
      endcase
      wmask_c = store ? WMASK_W'(base_mask << off) : '0;
   end

endmodule

// File: rtl/ysyx_22050133_lsu.sv
// One-entry load/store stage: accepts from EXU, runs at most one aligned
// data-memory transaction, and hands the result to writeback.
module ysyx_22050133_lsu
   import ysyx_22050133_lsu_pkg::*;
(
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  in_valid,
   output logic                                  in_ready,
   input  logic [ysyx_22050133_ctrl_mem_len-1:0] in_ctrl_mem,
   input  logic [XLEN-1:0]                       in_result,
   input  logic [XLEN-1:0]                       in_wdata,
   input  logic [REG_W-1:0]                      in_rd,
   output logic                                  out_valid,
   input  logic                                  out_ready,
   output logic [XLEN-1:0]                       out_data,
   output logic [REG_W-1:0]                      out_rd,
   output logic                                  out_err,
   output logic                                  mem_req_valid,
   input  logic                                  mem_req_ready,
   output logic [XLEN-1:0]                       mem_addr,
   output logic                                  mem_wen,
   output logic [XLEN-1:0]                       mem_wdata,
   output logic [WMASK_W-1:0]                    mem_wmask,
   input  logic                                  mem_rsp_valid,
   input  logic [XLEN-1:0]                       mem_rdata
);

   logic [1:0]         state_q;
   logic [1:0]         state_d;
   lsu_req_t           req_q;
   lsu_req_t           req_sel;
   logic               accept;
   logic               is_mem;
   logic [XLEN-1:0]    lane_wdata_c;
   logic [WMASK_W-1:0] wmask_c;
   logic [XLEN-1:0]    load_data_c;
   logic               misaligned_c;

   assign in_ready = (state_q == ST_IDLE) && !out_valid;
   assign accept   = in_valid && in_ready;
   assign is_mem   = in_ctrl_mem[CTRL_MEM_BIT];

   // Aligner sees the incoming op while idle, the captured op afterwards
   always_comb begin
      req_sel.store = in_ctrl_mem[CTRL_STORE_BIT];
      req_sel.uns   = in_ctrl_mem[CTRL_UNS_BIT];
      req_sel.size  = in_ctrl_mem[1:0];
      req_sel.off   = in_result[2:0];
      if (state_q != ST_IDLE) begin
         req_sel = req_q;
      end
   end

   ysyx_22050133_lsu_align u_align (
      .store        (req_sel.store),
      .uns          (req_sel.uns),
      .size         (req_sel.size),
      .off          (req_sel.off),
      .wdata        (in_wdata),
      .rdata        (mem_rdata),
      .lane_wdata_c (lane_wdata_c),
      .wmask_c      (wmask_c),
      .load_data_c  (load_data_c),
      .misaligned_c (misaligned_c)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (accept)        state_d = (is_mem && !misaligned_c) ? ST_REQ : ST_DONE;
         ST_REQ:  if (mem_req_ready) state_d = ST_WAIT;
         ST_WAIT: if (mem_rsp_valid) state_d = ST_DONE;
         ST_DONE: if (out_ready)     state_d = ST_IDLE;
         default:                    state_d = ST_IDLE;
      endcase
   end

   // Registered outputs and captured request
   always_ff @(posedge clk) begin
      if (rst) begin
         req_q         <= '0;
         out_valid     <= 1'b0;
         out_data      <= '0;
         out_rd        <= '0;
         out_err       <= 1'b0;
         mem_req_valid <= 1'b0;
         mem_addr      <= '0;
         mem_wen       <= 1'b0;
         mem_wdata     <= '0;
         mem_wmask     <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  req_q  <= req_sel;
                  out_rd <= in_rd;
                  if (!is_mem) begin
                     out_valid <= 1'b1;
                     out_data  <= in_result;
                     out_err   <= 1'b0;
                  end else if (misaligned_c) begin
                     out_valid <= 1'b1;
                     out_data  <= '0;
                     out_err   <= 1'b1;
                  end else begin
                     out_err       <= 1'b0;
                     mem_req_valid <= 1'b1;
                     mem_addr      <= {in_result[XLEN-1:3], 3'b000};
                     mem_wen       <= in_ctrl_mem[CTRL_STORE_BIT];
                     mem_wdata     <= lane_wdata_c;
                     mem_wmask     <= wmask_c;
                  end
               end
            end
            ST_REQ: begin
               if (mem_req_ready) mem_req_valid <= 1'b0;
            end
            ST_WAIT: begin
               if (mem_rsp_valid) begin
                  out_valid <= 1'b1;
                  out_data  <= req_q.store ? '0 : load_data_c;
               end
            end
            default: begin
               if (out_ready) out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_22050133_lsu.sv
// Directed bench for the LSU: pass-through, loads/stores at several lanes,
// misalignment, handshake stalls, and reset mid-transaction.
module tb_ysyx_22050133_lsu;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_ctrl_mem;
   logic [63:0] in_result;
   logic [63:0] in_wdata;
   logic [4:0]  in_rd;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_data;
   logic [4:0]  out_rd;
   logic        out_err;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [63:0] mem_addr;
   logic        mem_wen;
   logic [63:0] mem_wdata;
   logic [7:0]  mem_wmask;
   logic        mem_rsp_valid;
   logic [63:0] mem_rdata;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ysyx_22050133_lsu dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_ctrl_mem   (in_ctrl_mem),
      .in_result     (in_result),
      .in_wdata      (in_wdata),
      .in_rd         (in_rd),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_data      (out_data),
      .out_rd        (out_rd),
      .out_err       (out_err),
      .mem_req_valid (mem_req_valid),
      .mem_req_ready (mem_req_ready),
      .mem_addr      (mem_addr),
      .mem_wen       (mem_wen),
      .mem_wdata     (mem_wdata),
      .mem_wmask     (mem_wmask),
      .mem_rsp_valid (mem_rsp_valid),
      .mem_rdata     (mem_rdata)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Presents one instruction for a single cycle; returns just after the accepting edge
   task automatic issue(input logic [4:0] ctrl, input logic [63:0] res,
                        input logic [63:0] wdata, input logic [4:0] rd);
      in_valid    = 1'b1;
      in_ctrl_mem = ctrl;
      in_result   = res;
      in_wdata    = wdata;
      in_rd       = rd;
      chk("in_ready_before_issue", 64'(in_ready), 64'd1);
      tick;
      in_valid = 1'b0;
   endtask

   // Minimum-latency memory op: ready in first REQ cycle, response in first WAIT cycle
   task automatic mem_fast(input string tag, input logic [4:0] ctrl, input logic [63:0] addr,
                           input logic [63:0] wdata, input logic [4:0] rd, input logic [63:0] rdata,
                           input logic [63:0] exp_addr, input logic [7:0] exp_wmask,
                           input logic [63:0] exp_wdata, input logic [63:0] exp_data);
      issue(ctrl, addr, wdata, rd);
      chk({tag, "_req_valid"}, 64'(mem_req_valid), 64'd1);
      chk({tag, "_addr"}, mem_addr, exp_addr);
      chk({tag, "_wen"}, 64'(mem_wen), 64'(ctrl[3]));
      chk({tag, "_wmask"}, 64'(mem_wmask), 64'(exp_wmask));
      chk({tag, "_wdata"}, mem_wdata, exp_wdata);
      chk({tag, "_no_early_out"}, 64'(out_valid), 64'd0);
      mem_req_ready = 1'b1;
      tick;
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b1;
      mem_rdata     = rdata;
      chk({tag, "_req_drop"}, 64'(mem_req_valid), 64'd0);
      tick;
      mem_rsp_valid = 1'b0;
      chk({tag, "_out_valid"}, 64'(out_valid), 64'd1);
      chk({tag, "_out_data"}, out_data, exp_data);
      chk({tag, "_out_rd"}, 64'(out_rd), 64'(rd));
      chk({tag, "_out_err"}, 64'(out_err), 64'd0);
      chk({tag, "_in_ready_busy"}, 64'(in_ready), 64'd0);
      tick;
      chk({tag, "_out_clear"}, 64'(out_valid), 64'd0);
   endtask

   initial begin
      rst           = 1'b1;
      in_valid      = 1'b0;
      in_ctrl_mem   = '0;
      in_result     = '0;
      in_wdata      = '0;
      in_rd         = '0;
      out_ready     = 1'b1;
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_rdata     = '0;
      tick;
      tick;
      rst = 1'b0;

      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data", out_data, 64'd0);
      chk("rst_out_err", 64'(out_err), 64'd0);
      chk("rst_req_valid", 64'(mem_req_valid), 64'd0);
      chk("rst_wmask", 64'(mem_wmask), 64'd0);
      chk("rst_addr", mem_addr, 64'd0);

      // Non-memory pass-through
      issue(5'b00000, 64'h1234, 64'h0, 5'd5);
      chk("alu_out_valid", 64'(out_valid), 64'd1);
      chk("alu_out_data", out_data, 64'h1234);
      chk("alu_out_rd", 64'(out_rd), 64'd5);
      chk("alu_no_req", 64'(mem_req_valid), 64'd0);
      tick;
      chk("alu_out_clear", 64'(out_valid), 64'd0);

      mem_fast("lb", 5'b10000, 64'h8000_0003, 64'h0, 5'd1, 64'h0000_0000_8000_0000,
               64'h8000_0000, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_FF80);
      mem_fast("lbu", 5'b10100, 64'h8000_0003, 64'h0, 5'd2, 64'h0000_0000_8000_0000,
               64'h8000_0000, 8'h00, 64'h0, 64'h80);
      mem_fast("sh", 5'b11001, 64'h8000_0006, 64'hBEEF, 5'd3, 64'hDEAD,
               64'h8000_0000, 8'hC0, 64'hBEEF_0000_0000_0000, 64'h0);
      mem_fast("lh", 5'b10001, 64'h8000_0012, 64'h0, 5'd4, 64'h1111_2222_F00D_3333,
               64'h8000_0010, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_F00D);
      mem_fast("ld", 5'b10011, 64'h8000_0018, 64'h0, 5'd6, 64'h0123_4567_89AB_CDEF,
               64'h8000_0018, 8'h00, 64'h0, 64'h0123_4567_89AB_CDEF);
      mem_fast("sb7", 5'b11000, 64'h8000_0007, 64'h1234_5678_9ABC_DEA5, 5'd8, 64'h0,
               64'h8000_0000, 8'h80, 64'hA500_0000_0000_0000, 64'h0);
      mem_fast("sd", 5'b11011, 64'h8000_0020, 64'hCAFE_F00D_1234_5678, 5'd10, 64'h0,
               64'h8000_0020, 8'hFF, 64'hCAFE_F00D_1234_5678, 64'h0);

      // Misaligned: LW@+2, SH@+1, LD@+4
      begin
         logic [4:0]  mis_ctrl [3] = '{5'b10010, 5'b11001, 5'b10011};
         logic [63:0] mis_addr [3] = '{64'h8000_0002, 64'h8000_0001, 64'h8000_0004};
         for (int i = 0; i < 3; i++) begin
            issue(mis_ctrl[i], mis_addr[i], 64'hFFFF, 5'd11);
            chk($sformatf("mis%0d_out_valid", i), 64'(out_valid), 64'd1);
            chk($sformatf("mis%0d_err", i), 64'(out_err), 64'd1);
            chk($sformatf("mis%0d_data", i), out_data, 64'd0);
            chk($sformatf("mis%0d_no_req", i), 64'(mem_req_valid), 64'd0);
            tick;
            chk($sformatf("mis%0d_no_req_after", i), 64'(mem_req_valid), 64'd0);
            chk($sformatf("mis%0d_clear", i), 64'(out_valid), 64'd0);
         end
      end

      // Stalls on every handshake; responses outside WAIT must be ignored
      out_ready = 1'b0;
      issue(5'b10110, 64'h8000_0004, 64'h0, 5'd9);
      mem_rsp_valid = 1'b1;
      mem_rdata     = 64'hFFFF_FFFF_FFFF_FFFF;
      for (int i = 0; i < 3; i++) begin
         chk("stall_req_valid", 64'(mem_req_valid), 64'd1);
         chk("stall_req_addr", mem_addr, 64'h8000_0000);
         chk("stall_req_wen", 64'(mem_wen), 64'd0);
         chk("stall_req_in_ready", 64'(in_ready), 64'd0);
         tick;
      end
      chk("stall_req_valid_last", 64'(mem_req_valid), 64'd1);
      mem_req_ready = 1'b1;
      tick;
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         chk("stall_wait_req_valid", 64'(mem_req_valid), 64'd0);
         chk("stall_wait_out_valid", 64'(out_valid), 64'd0);
         chk("stall_wait_in_ready", 64'(in_ready), 64'd0);
         tick;
      end
      mem_rsp_valid = 1'b1;
      mem_rdata     = 64'h8765_4321_0000_0000;
      tick;
      mem_rsp_valid = 1'b0;
      in_valid      = 1'b1;
      in_ctrl_mem   = 5'b00000;
      in_result     = 64'h5555;
      in_rd         = 5'd30;
      for (int i = 0; i < 2; i++) begin
         chk("stall_done_valid", 64'(out_valid), 64'd1);
         chk("stall_done_data", out_data, 64'h8765_4321);
         chk("stall_done_rd", 64'(out_rd), 64'd9);
         chk("stall_done_in_ready", 64'(in_ready), 64'd0);
         tick;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      chk("stall_done_hold", out_data, 64'h8765_4321);
      tick;
      chk("stall_out_clear", 64'(out_valid), 64'd0);
      chk("stall_in_ready_back", 64'(in_ready), 64'd1);

      // Reset while waiting for a response, then a stale response
      issue(5'b10011, 64'h8000_0008, 64'h0, 5'd3);
      mem_req_ready = 1'b1;
      tick;
      mem_req_ready = 1'b0;
      rst = 1'b1;
      tick;
      rst           = 1'b0;
      mem_rsp_valid = 1'b1;
      mem_rdata     = 64'h7777_7777_7777_7777;
      chk("rstw_in_ready", 64'(in_ready), 64'd1);
      chk("rstw_out_valid", 64'(out_valid), 64'd0);
      chk("rstw_req_valid", 64'(mem_req_valid), 64'd0);
      tick;
      mem_rsp_valid = 1'b0;
      chk("rstw_stale_out_valid", 64'(out_valid), 64'd0);
      chk("rstw_stale_in_ready", 64'(in_ready), 64'd1);
      issue(5'b00000, 64'hABCD, 64'h0, 5'd7);
      chk("rstw_next_valid", 64'(out_valid), 64'd1);
      chk("rstw_next_data", out_data, 64'hABCD);
      chk("rstw_next_rd", 64'(out_rd), 64'd7);
      tick;
      chk("rstw_next_clear", 64'(out_valid), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
